// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, data width and the baud divisor helper.
// Imported by both the TX driver and the baud monitor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Clocks per bit, rounded to the nearest integer.
  function automatic int uart_divisor(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000 + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with registered occupancy count; push is refused when full,
// pop is ignored when empty. Storage is not reset, only the pointers.
module uart_byte_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_driver.sv
// 8N1/8N2 UART transmitter fed from a byte FIFO. The line output is registered;
// frames chain back-to-back with no idle gap while the FIFO has data.
module uart_tx_driver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [UART_DATA_BITS-1:0]        in_byte_i,
  output logic                             uart_tx_o,
  output logic                             busy_o,
  output logic                             tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int DIVISOR = uart_divisor(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_driver: STOP_BITS must be 1 or 2");
  end

  logic [1:0]                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d, bit_nxt;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;

  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_head;
  logic                      baud_end;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid_i),
    .wdata_i (in_byte_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign baud_end = (cnt_q == CNT_W'(DIVISOR - 1));
  assign bit_nxt  = bit_q + 3'd1;

  // bit_q doubles as the stop-bit index while in STOP.
  always_comb begin
    state_d  = state_q;
    cnt_d    = baud_end ? '0 : cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == LAST_DATA) begin
            state_d = S_STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (bit_q == LAST_STOP) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_head;
              state_d  = S_START;
              tx_d     = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx_o  = tx_q;
  assign in_ready_o = !fifo_full;
  assign busy_o     = (state_q != S_IDLE) || !fifo_empty;
  assign tx_done_o  = (state_q == S_STOP) && baud_end && (bit_q == LAST_STOP);

endmodule

// File: tb/tb_uart_tx_driver.sv
// Bench for uart_tx_driver: directed pushes feed an expected-byte queue; a
// line monitor decodes every frame, checks each clock of it and pops the queue.
module tb_uart_tx_driver;

  localparam int DIV   = 234;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       uart_tx;
  logic       busy;
  logic       tx_done;
  logic [4:0] fifo_count;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         start_log[$];
  int         done_log[$];

  uart_tx_driver dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_byte_i    (in_byte),
    .uart_tx_o    (uart_tx),
    .busy_o       (busy),
    .tx_done_o    (tx_done),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: one sample per clock, on the falling edge.
  logic       m_active = 1'b0;
  int         m_pos;
  logic [9:0] m_frame;
  logic       m_bad, m_done_bad;
  logic [7:0] m_rx;

  always @(negedge clk) begin
    if (tx_done === 1'b1) done_log.push_back(cyc);
    if (reset !== 1'b1) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (uart_tx !== m_frame[m_pos / DIV]) m_bad = 1'b1;
      if (tx_done !== (m_pos == FRAME - 1)) m_done_bad = 1'b1;
      if (m_pos % DIV == DIV / 2 && m_pos / DIV >= 1 && m_pos / DIV <= 8)
        m_rx[m_pos / DIV - 1] = uart_tx;
      if (m_pos == FRAME - 1) begin
        check("frame_bits", {31'd0, m_bad}, 32'd0);
        check("tx_done_position", {31'd0, m_done_bad}, 32'd0);
        rx_log.push_back(m_rx);
        m_active = 1'b0;
      end
      m_pos++;
    end else begin
      if (tx_done === 1'b1) check("tx_done_outside_frame", {31'd0, tx_done}, 32'd0);
      if (uart_tx === 1'b0) begin
        start_log.push_back(cyc);
        check("frame_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        m_frame    = {1'b1, (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00, 1'b0};
        m_pos      = 1;
        m_bad      = 1'b0;
        m_done_bad = 1'b0;
        m_rx       = '0;
        m_active   = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rx_log.delete();
    start_log.delete();
    done_log.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    in_valid = 1'b1;
    in_byte  = b;
    acc      = in_ready;
    tick();
    if (acc) exp_q.push_back(b);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (start_log.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", start_log.size(), 32'd1);
  endtask

  initial begin
    logic [7:0] hi [3];
    int acc_n;
    logic acc;
    int n;
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;

    reset = 1'b0; in_valid = 1'b0; in_byte = 8'h00;

    check("divisor_default", uart_pkg::uart_divisor(27, 115200), 32'd234);
    check("divisor_1mhz_9600", uart_pkg::uart_divisor(1, 9600), 32'd104);

    // Reset: in_valid must be ignored on reset edges.
    in_valid = 1'b1; in_byte = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    repeat (2) tick();

    // Single byte: line low one edge after the push edge.
    clear_logs();
    in_valid = 1'b1; in_byte = 8'h55;
    tick();
    exp_q.push_back(8'h55);
    in_valid = 1'b0;
    check("single_count_after_push", {27'd0, fifo_count}, 32'd1);
    check("single_tx_high_at_push", {31'd0, uart_tx}, 32'd1);
    check("single_busy", {31'd0, busy}, 32'd1);
    tick();
    check("single_tx_low_next_edge", {31'd0, uart_tx}, 32'd0);
    check("single_count_after_pop", {27'd0, fifo_count}, 32'd0);
    wait_idle(3000);
    check("single_done_count", done_log.size(), 32'd1);
    if (done_log.size() == 1 && start_log.size() == 1)
      check("single_done_clock", done_log[0] - start_log[0] + 1, 32'd2340);
    check("single_rx_count", rx_log.size(), 32'd1);
    if (rx_log.size() == 1) check("single_rx_byte", {24'd0, rx_log[0]}, 32'h55);
    repeat (5) tick();

    // "Hi\n": three frames, busy drops 7020 clocks after the first start edge.
    clear_logs();
    for (int i = 0; i < 3; i++) push_byte(hi[i]);
    wait_idle(8000);
    check("hi_frames", start_log.size(), 32'd3);
    if (start_log.size() >= 1) check("hi_busy_drop", cyc - start_log[0], 32'd7020);
    check("hi_rx_count", rx_log.size(), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < rx_log.size()) check("hi_rx_byte", {24'd0, rx_log[i]}, {24'd0, hi[i]});
    repeat (5) tick();

    // Back-to-back frames with no idle gap.
    clear_logs();
    push_byte(8'h41);
    push_byte(8'h42);
    wait_idle(6000);
    check("b2b_done_pulses", done_log.size(), 32'd2);
    check("b2b_starts", start_log.size(), 32'd2);
    if (done_log.size() == 2) check("b2b_done_spacing", done_log[1] - done_log[0], 32'd2340);
    if (done_log.size() >= 1 && start_log.size() == 2)
      check("b2b_no_gap", start_log[1] - done_log[0], 32'd1);
    if (rx_log.size() == 2) check("b2b_rx_second", {24'd0, rx_log[1]}, 32'h42);
    repeat (5) tick();

    // Full FIFO: hold in_valid for 20 cycles.
    clear_logs();
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'h10 + 8'(i);
      acc      = in_ready;
      tick();
      if (acc) begin
        exp_q.push_back(in_byte);
        acc_n++;
      end
    end
    in_valid = 1'b0;
    check("full_accepted", acc_n, 32'd17);
    check("full_count", {27'd0, fifo_count}, 32'd16);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    n = 0;
    while (fifo_count == 5'd16 && n < 2500) begin
      tick();
      n++;
    end
    check("full_count_after_pop", {27'd0, fifo_count}, 32'd15);
    check("full_ready_after_pop", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_q.delete();
    check("flush_count", {27'd0, fifo_count}, 32'd0);
    check("flush_tx", {31'd0, uart_tx}, 32'd1);
    repeat (5) tick();

    // Reset at clock 1000 of a frame abandons it.
    clear_logs();
    push_byte(8'h33);
    wait_start(100);
    n = 0;
    while (start_log.size() > 0 && cyc - start_log[0] < 999 && n < 2000) begin
      tick();
      n++;
    end
    reset = 1'b0;
    tick();
    check("midrst_tx", {31'd0, uart_tx}, 32'd1);
    check("midrst_count", {27'd0, fifo_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    repeat (3000) tick();
    check("midrst_no_done", done_log.size(), 32'd0);
    push_byte(8'h5A);
    wait_idle(3000);
    check("midrst_new_rx_count", rx_log.size(), 32'd1);
    if (rx_log.size() == 1) check("midrst_new_rx_byte", {24'd0, rx_log[0]}, 32'h5A);
    check("midrst_new_done", done_log.size(), 32'd1);

    repeat (5) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
